// File: rtl/ddr3_wr_arbiter.sv
// Write-port arbiter in front of the DDR3 controller: priority plus
// round-robin selection, command forwarding and per-channel data muxing.
module ddr3_wr_arbiter #(
   parameter int CHN_NUM    = 4,
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 27,
   parameter int LEN_WIDTH  = 12
) (
   input  logic                           i_ddr_clk,
   input  logic                           i_rst,
   input  logic [CHN_NUM-1:0]             i_chn_req,
   input  logic [CHN_NUM*16-1:0]          i_chn_priority,
   input  logic [CHN_NUM*ADDR_WIDTH-1:0]  i_chn_start_addr,
   input  logic [CHN_NUM*LEN_WIDTH-1:0]   i_chn_data_length,
   input  logic [CHN_NUM*DATA_WIDTH-1:0]  i_chn_wdata,
   output logic [CHN_NUM-1:0]             o_chn_ack,
   output logic [CHN_NUM-1:0]             o_chn_wdata_rdy,
   output logic [CHN_NUM-1:0]             o_chn_wr_done,
   output logic                           o_mc_wr_req,
   output logic [ADDR_WIDTH-1:0]          o_mc_addr,
   output logic [LEN_WIDTH-1:0]           o_mc_len,
   input  logic                           i_mc_cmd_ack,
   input  logic                           i_mc_wdata_rdy,
   output logic [DATA_WIDTH-1:0]          o_mc_wdata,
   input  logic                           i_mc_wr_done,
   output logic [2:0]                     o_grant_chn,
   output logic                           o_busy,
   output logic                           o_err
);

   localparam int IW = (CHN_NUM > 1) ? $clog2(CHN_NUM) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_CMD,
      S_DATA,
      S_WAIT_DONE,
      S_DONE
   } state_t;

   state_t                r_state;
   logic [IW-1:0]         r_win;
   logic [IW-1:0]         r_grant;
   logic [IW-1:0]         r_rr_ptr;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [LEN_WIDTH-1:0]  r_len;
   logic [LEN_WIDTH-1:0]  r_cnt;
   logic                  r_err;

   logic [15:0]           w_prio  [CHN_NUM];
   logic [ADDR_WIDTH-1:0] w_addr  [CHN_NUM];
   logic [LEN_WIDTH-1:0]  w_len   [CHN_NUM];
   logic [DATA_WIDTH-1:0] w_wdata [CHN_NUM];

   genvar gi;
   generate
      for (gi = 0; gi < CHN_NUM; gi++) begin : g_unpack
         assign w_prio[gi]  = i_chn_priority[gi*16 +: 16];
         assign w_addr[gi]  = i_chn_start_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign w_len[gi]   = i_chn_data_length[gi*LEN_WIDTH +: LEN_WIDTH];
         assign w_wdata[gi] = i_chn_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // Scan in round-robin order; strict '>' lets the first tied channel win
   logic [IW-1:0] w_win;
   logic [IW-1:0] w_idx;
   logic [15:0]   w_best;
   logic          w_found;

   always_comb begin
      w_win   = '0;
      w_idx   = '0;
      w_best  = '0;
      w_found = 1'b0;
      for (int k = 0; k < CHN_NUM; k++) begin
         w_idx = IW'((int'(r_rr_ptr) + 1 + k) % CHN_NUM);
         if (i_chn_req[w_idx] && (!w_found || w_prio[w_idx] > w_best)) begin
            w_found = 1'b1;
            w_best  = w_prio[w_idx];
            w_win   = w_idx;
         end
      end
   end

   logic [CHN_NUM-1:0] w_grant_oh;

   always_comb begin
      w_grant_oh          = '0;
      w_grant_oh[r_grant] = 1'b1;
   end

   logic w_last_beat;
   assign w_last_beat = i_mc_wdata_rdy && ((r_cnt + 1'b1) == r_len);

   always_ff @(posedge i_ddr_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_win    <= '0;
         r_grant  <= '0;
         r_rr_ptr <= '0;
         r_addr   <= '0;
         r_len    <= '0;
         r_cnt    <= '0;
         r_err    <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (|i_chn_req) begin
                  r_win   <= w_win;
                  r_state <= S_LATCH;
               end
            end
            S_LATCH: begin
               r_grant <= r_win;
               r_addr  <= w_addr[r_win];
               r_len   <= w_len[r_win];
               r_cnt   <= '0;
               r_state <= (w_len[r_win] == '0) ? S_DONE : S_CMD;
            end
            S_CMD: begin
               if (i_mc_cmd_ack)
                  r_state <= S_DATA;
            end
            S_DATA: begin
               if (i_mc_wdata_rdy)
                  r_cnt <= r_cnt + 1'b1;
               // done together with the final beat is a clean finish
               if (w_last_beat) begin
                  r_state <= i_mc_wr_done ? S_DONE : S_WAIT_DONE;
               end else if (i_mc_wr_done) begin
                  r_err   <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (i_mc_wr_done)
                  r_state <= S_DONE;
            end
            S_DONE: begin
               r_rr_ptr <= r_grant;
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_chn_ack       = (r_state == S_CMD && i_mc_cmd_ack) ? w_grant_oh : '0;
   assign o_chn_wdata_rdy = (r_state == S_DATA && i_mc_wdata_rdy) ? w_grant_oh : '0;
   assign o_chn_wr_done   = (r_state == S_DONE) ? w_grant_oh : '0;
   assign o_mc_wr_req     = (r_state == S_CMD);
   assign o_mc_addr       = r_addr;
   assign o_mc_len        = r_len;
   assign o_mc_wdata      = w_wdata[r_grant];
   assign o_grant_chn     = 3'(r_grant);
   assign o_busy          = (r_state != S_IDLE);
   assign o_err           = r_err;

endmodule

// File: tb/tb_ddr3_wr_arbiter.sv
// Scoreboard bench for ddr3_wr_arbiter with a small controller model
// and per-channel request models.
module tb_ddr3_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 128;
   localparam int AW = 27;
   localparam int LW = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [N-1:0]    req;
   logic [N*16-1:0] prio;
   logic [N*AW-1:0] addr;
   logic [N*LW-1:0] len;
   logic [N*DW-1:0] wdata;
   logic [N-1:0]    ack;
   logic [N-1:0]    wrdy;
   logic [N-1:0]    wdone;
   logic            mc_req;
   logic [AW-1:0]   mc_addr;
   logic [LW-1:0]   mc_len;
   logic            mc_ack;
   logic            mc_rdy;
   logic [DW-1:0]   mc_wdata;
   logic            mc_done;
   logic [2:0]      gnt;
   logic            busy;
   logic            err;

   ddr3_wr_arbiter #(
      .CHN_NUM    (N),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .LEN_WIDTH  (LW)
   ) dut (
      .i_ddr_clk         (clk),
      .i_rst             (rst),
      .i_chn_req         (req),
      .i_chn_priority    (prio),
      .i_chn_start_addr  (addr),
      .i_chn_data_length (len),
      .i_chn_wdata       (wdata),
      .o_chn_ack         (ack),
      .o_chn_wdata_rdy   (wrdy),
      .o_chn_wr_done     (wdone),
      .o_mc_wr_req       (mc_req),
      .o_mc_addr         (mc_addr),
      .o_mc_len          (mc_len),
      .i_mc_cmd_ack      (mc_ack),
      .i_mc_wdata_rdy    (mc_rdy),
      .o_mc_wdata        (mc_wdata),
      .i_mc_wr_done      (mc_done),
      .o_grant_chn       (gnt),
      .o_busy            (busy),
      .o_err             (err)
   );

   typedef struct {
      int            chn;
      logic [AW-1:0] a;
      logic [LW-1:0] l;
   } cmd_t;

   typedef struct {
      int chn;
      int beats;
   } done_t;

   cmd_t  cmd_q[$];
   done_t done_q[$];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int beats = 0;
   int cur_g = 0;
   int n_ack = 0;
   int n_req = 0;
   int done_cyc = 0;
   int md_cyc = 0;
   int early_n = 0;
   int hold_c = -1;
   int mc_phase = 0;
   int mc_left = 0;
   int rereq [N];

   logic         s_hs;
   logic         s_beat;
   logic         s_req;
   logic [N-1:0] s_ack;
   logic [N-1:0] s_done;

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] oh(input int c);
      return N'(1) << c;
   endfunction

   task automatic set_chn(input int c, input logic [15:0] p,
                          input logic [AW-1:0] a, input logic [LW-1:0] l);
      prio[c*16 +: 16] = p;
      addr[c*AW +: AW] = a;
      len[c*LW +: LW]  = l;
   endtask

   task automatic push_cmd(input int c, input logic [AW-1:0] a,
                           input logic [LW-1:0] l);
      cmd_t e;
      e.chn = c;
      e.a   = a;
      e.l   = l;
      cmd_q.push_back(e);
   endtask

   task automatic push_done(input int c, input int nb);
      done_t d;
      d.chn   = c;
      d.beats = nb;
      done_q.push_back(d);
   endtask

   task automatic exp_burst(input int c, input logic [AW-1:0] a,
                            input logic [LW-1:0] l, input int nb);
      if (l != 0)
         push_cmd(c, a, l);
      push_done(c, nb);
   endtask

   // Inputs change on the falling edge, decided from the previous sample
   task automatic drive();
      mc_done = 1'b0;
      if (mc_phase == 1) begin
         if (s_beat)
            mc_left--;
         if (mc_left == 0) begin
            mc_rdy   = 1'b0;
            mc_done  = 1'b1;
            md_cyc   = cyc;
            mc_phase = 0;
         end
      end else if (s_hs) begin
         mc_ack   = 1'b0;
         mc_left  = (early_n > 0) ? early_n : int'(mc_len);
         mc_phase = 1;
         mc_rdy   = 1'b1;
      end else begin
         mc_ack = s_req;
      end
      for (int c = 0; c < N; c++) begin
         if ((s_ack[c] && c != hold_c) || s_done[c]) begin
            req[c] = 1'b0;
            if (s_done[c] && rereq[c] > 0) begin
               rereq[c]--;
               req[c] = 1'b1;
            end
         end
      end
      for (int i = 0; i < N*DW/32; i++)
         wdata[i*32 +: 32] = $urandom;
   endtask

   task automatic sample();
      cmd_t  e;
      done_t d;
      s_hs   = mc_req && mc_ack;
      s_beat = mc_rdy;
      s_req  = mc_req;
      s_ack  = ack;
      s_done = wdone;
      if (mc_req)
         n_req++;
      if (ack != 0)
         n_ack++;
      if (s_hs) begin
         if (cmd_q.size() == 0) begin
            check("cmd_q_nonempty", 128'(cmd_q.size()), 128'(1));
         end else begin
            e     = cmd_q.pop_front();
            cur_g = e.chn;
            check("cmd_grant", 128'(gnt), 128'(e.chn));
            check("cmd_addr", 128'(mc_addr), 128'(e.a));
            check("cmd_len", 128'(mc_len), 128'(e.l));
            check("cmd_ack", 128'(ack), 128'(oh(e.chn)));
         end
         beats = 0;
      end else if (ack != 0) begin
         check("ack_spurious", 128'(ack), 128'(0));
      end
      if (mc_rdy) begin
         beats++;
         check("beat_rdy", 128'(wrdy), 128'(oh(cur_g)));
         check("beat_data", 128'(mc_wdata), 128'(wdata[cur_g*DW +: DW]));
      end
      if (wdone != 0) begin
         done_cyc = cyc;
         if (done_q.size() == 0) begin
            check("done_q_nonempty", 128'(done_q.size()), 128'(1));
         end else begin
            d = done_q.pop_front();
            check("done_chn", 128'(wdone), 128'(oh(d.chn)));
            check("done_beats", 128'(beats), 128'(d.beats));
            if (d.beats > 0)
               check("done_lat", 128'(cyc - md_cyc), 128'(1));
         end
         beats = 0;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      drive();
      #1;
      sample();
   endtask

   task automatic wait_idle(input string tag, input int maxc);
      int n;
      n = 0;
      while ((cmd_q.size() != 0 || done_q.size() != 0 || busy || req != 0)
             && n < maxc) begin
         tick();
         n++;
      end
      check({"idle_", tag}, 128'(n < maxc), 128'(1));
      cmd_q.delete();
      done_q.delete();
   endtask

   task automatic mc_clear();
      mc_ack   = 1'b0;
      mc_rdy   = 1'b0;
      mc_done  = 1'b0;
      mc_phase = 0;
      s_hs     = 1'b0;
      s_beat   = 1'b0;
      s_req    = 1'b0;
      s_ack    = '0;
      s_done   = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not end, got timeout want finish");
      $fatal(1);
   end

   initial begin
      int t_ack;
      int t_req;
      int t0;
      int n;
      rst   = 1'b1;
      req   = '0;
      prio  = '0;
      addr  = '0;
      len   = '0;
      wdata = '0;
      for (int c = 0; c < N; c++)
         rereq[c] = 0;
      mc_clear();
      repeat (3) tick();
      check("rst_outs",
            128'({busy, mc_req, ack, wrdy, wdone, gnt, err, mc_addr, mc_len}),
            128'(0));
      rst = 1'b0;
      tick();

      // single request on channel 1
      set_chn(1, 16'd1, 27'h0123456, 12'd4);
      exp_burst(1, 27'h0123456, 12'd4, 4);
      t_ack  = n_ack;
      req[1] = 1'b1;
      wait_idle("single", 100);
      check("single_acks", 128'(n_ack - t_ack), 128'(1));
      check("single_err", 128'(err), 128'(0));

      // higher priority wins
      set_chn(0, 16'd5, 27'h0000100, 12'd3);
      set_chn(2, 16'd9, 27'h0000200, 12'd2);
      exp_burst(2, 27'h0000200, 12'd2, 2);
      exp_burst(0, 27'h0000100, 12'd3, 3);
      req[0] = 1'b1;
      req[2] = 1'b1;
      wait_idle("prio", 100);

      // zero length: no command, no ack
      set_chn(3, 16'd1, 27'h0000300, 12'd0);
      exp_burst(3, 27'h0000300, 12'd0, 0);
      t_ack  = n_ack;
      t_req  = n_req;
      t0     = cyc;
      req[3] = 1'b1;
      wait_idle("zero", 50);
      check("zero_ack", 128'(n_ack - t_ack), 128'(0));
      check("zero_mc_req", 128'(n_req - t_req), 128'(0));
      check("zero_lat", 128'(done_cyc - t0), 128'(2));

      // equal priorities rotate, each channel requests twice
      for (int c = 0; c < N; c++) begin
         set_chn(c, 16'd7, 27'(32'h1000 + c*64), 12'(c + 2));
         rereq[c] = 1;
      end
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < N; c++)
            exp_burst(c, 27'(32'h1000 + c*64), 12'(c + 2), c + 2);
      req = '1;
      wait_idle("rr", 400);

      // controller finishes after 5 of 8 beats
      set_chn(1, 16'd3, 27'h0ABCDEF, 12'd8);
      push_cmd(1, 27'h0ABCDEF, 12'd8);
      push_done(1, 5);
      early_n = 5;
      req[1]  = 1'b1;
      wait_idle("early", 100);
      early_n = 0;
      check("early_err", 128'(err), 128'(1));
      set_chn(2, 16'd3, 27'h0000777, 12'd3);
      exp_burst(2, 27'h0000777, 12'd3, 3);
      req[2] = 1'b1;
      wait_idle("after_early", 100);
      check("err_sticky", 128'(err), 128'(1));

      // reset lands on the second data beat; request stays up
      set_chn(2, 16'd4, 27'h7FFFFFF, 12'd6);
      push_cmd(2, 27'h7FFFFFF, 12'd6);
      exp_burst(2, 27'h7FFFFFF, 12'd6, 6);
      hold_c = 2;
      req[2] = 1'b1;
      n = 0;
      while (beats < 2 && n < 100) begin
         tick();
         n++;
      end
      check("rst_wait_beat2", 128'(n < 100), 128'(1));
      rst = 1'b1;
      mc_clear();
      #1;
      check("rst_mid_outs",
            128'({busy, mc_req, ack, wrdy, wdone, gnt, err, mc_addr, mc_len}),
            128'(0));
      check("rst_req_held", 128'(req), 128'(oh(2)));
      repeat (2) tick();
      hold_c = -1;
      beats  = 0;
      rst    = 1'b0;
      wait_idle("rst_retry", 200);
      check("rst_err_clear", 128'(err), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
